// File: rtl/pb_event_pkg.sv
// Shared types and constants for the push-button event classifier.
package pb_event_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StLongHeld,
    StWaitSecond,
    StPress2
  } pb_state_e;

endpackage

// File: rtl/pb_event_classifier.sv
// Classifies a debounced button level into short, long and double press pulses.
// One FSM shares a single counter for both the hold time and the release gap.
module pb_event_classifier
  import pb_event_pkg::*;
#(
  parameter int unsigned LONG_TICKS = 100,
  parameter int unsigned DOUBLE_GAP = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_debounced,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held
);

  if (LONG_TICKS < 2 || LONG_TICKS > 255) begin : gen_bad_long_ticks
    $error("LONG_TICKS must be in 2..255");
  end
  if (DOUBLE_GAP < 2 || DOUBLE_GAP > 255) begin : gen_bad_double_gap
    $error("DOUBLE_GAP must be in 2..255");
  end

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(DOUBLE_GAP - 1);

  pb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_d, long_d, double_d, held_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      held         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      short_press  <= short_d;
      long_press   <= long_d;
      double_press <= double_d;
      held         <= held_d;
    end
  end

  // Release beats the long threshold; a new press beats the gap timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pb_debounced) begin
          state_d = StPress1;
          cnt_d   = '0;
        end
      end
      StPress1: begin
        if (!pb_debounced) begin
          state_d = StWaitSecond;
          cnt_d   = '0;
        end else if (cnt_q == LongLast) begin
          state_d = StLongHeld;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLongHeld: begin
        if (!pb_debounced) state_d = StIdle;
      end
      StWaitSecond: begin
        if (pb_debounced) begin
          state_d = StPress2;
        end else if (cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPress2: begin
        if (!pb_debounced) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    short_d  = (state_q == StWaitSecond) && !pb_debounced && (cnt_q == GapLast);
    long_d   = (state_q == StPress1) && pb_debounced && (cnt_q == LongLast);
    double_d = (state_q == StPress2) && !pb_debounced;
    held_d   = (state_d == StPress1) || (state_d == StLongHeld) || (state_d == StPress2);
  end

endmodule

// File: tb/tb_pb_event_classifier.sv
// Directed bench for pb_event_classifier with LONG_TICKS=8, DOUBLE_GAP=4.
module tb_pb_event_classifier;

  logic clk;
  logic rst_n;
  logic pb;
  logic short_press, long_press, double_press, held;

  int checks = 0;
  int errors = 0;

  pb_event_classifier #(
    .LONG_TICKS(8),
    .DOUBLE_GAP(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pb_debounced(pb),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .held        (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit i of each vector is the pb level sampled at edge i, or the output expected after it.
  task automatic run_seq(input string tag, input int n, input logic [63:0] pbv,
                         input logic [63:0] sv, input logic [63:0] lv,
                         input logic [63:0] dv, input logic [63:0] hv);
    for (int i = 0; i < n; i++) begin
      logic [3:0] exp_v, got_v;
      pb = pbv[i];
      @(posedge clk);
      @(negedge clk);
      exp_v = {sv[i], lv[i], dv[i], hv[i]};
      got_v = {short_press, long_press, double_press, held};
      checks++;
      assert (got_v === exp_v) else begin
        errors++;
        $error("FAIL %s edge %0d: short/long/double/held observed=%b expected=%b",
               tag, i, got_v, exp_v);
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    logic [3:0] got_v;
    got_v = {short_press, long_press, double_press, held};
    checks++;
    assert (got_v === 4'b0000) else begin
      errors++;
      $error("FAIL %s: short/long/double/held observed=%b expected=0000", tag, got_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pb    = 1'b0;
    #1;
    check_quiet("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Short press: 3 held edges, short pulse 4 edges after release.
    run_seq("short", 9, 64'h7, 64'h80, 64'h0, 64'h0, 64'h7);
    // Long press: 20 held edges, long pulse at entry+8, quiet release.
    run_seq("long", 26, 64'hFFFFF, 64'h0, 64'h100, 64'h0, 64'hFFFFF);
    // Release on the very edge that would have fired long: no long, later short.
    run_seq("long_edge_release", 14, 64'hFF, 64'h1000, 64'h0, 64'h0, 64'hFF);
    // Double press: 2 on, 2 off, 3 on, release -> double, never short.
    run_seq("double", 13, 64'h73, 64'h0, 64'h0, 64'h80, 64'h73);
    // Gap of 4 released edges, press on the edge that would time out: press wins.
    run_seq("gap4", 11, 64'h21, 64'h0, 64'h0, 64'h40, 64'h21);
    // Gap of 5: short fires, then the next press starts a fresh PRESS1.
    run_seq("gap5", 14, 64'hC1, 64'h1020, 64'h0, 64'h0, 64'hC1);

    // Reset in PRESS1 at cnt=5 with the button still down.
    run_seq("rst_pre", 6, 64'h3F, 64'h0, 64'h0, 64'h0, 64'h3F);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("rst_immediate");
    @(negedge clk);
    check_quiet("rst_hold1");
    @(negedge clk);
    check_quiet("rst_hold2");
    rst_n = 1'b1;
    run_seq("rst_post", 12, 64'h3FF, 64'h0, 64'h100, 64'h0, 64'h3FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pb_event_classifier.md
PB_EVENT_CLASSIFIER -- requirements
Module: pb_event_classifier

Interface
REQ-001 SHALL have parameter LONG_TICKS, default 100; held clocks that classify a long press (1 s at 100 Hz), legal range 2..255.
REQ-002 SHALL have parameter DOUBLE_GAP, default 30; maximum released clocks between two presses of a double press (0.3 s), legal range 2..255.
REQ-003 SHALL have port clk  input  1  the same 100 Hz clock that drives the debouncer; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pb_debounced  input  1  debounced button level from the same clk domain; 1 = pressed.
REQ-006 SHALL have port short_press  output  1  one-clock pulse for a single short press.
REQ-007 SHALL have port long_press  output  1  one-clock pulse when a press reaches LONG_TICKS.
REQ-008 SHALL have port double_press  output  1  one-clock pulse when the second press of a double press is released.
REQ-009 SHALL have port held  output  1  level; 1 while the FSM is in PRESS1, LONG_HELD or PRESS2.

Function
REQ-010 SHALL implement FSM states IDLE, PRESS1, LONG_HELD, WAIT_SECOND and PRESS2, plus one 8-bit counter `cnt`.
REQ-011 SHALL sample pb_debounced directly at each edge; no extra synchroniser; edge e is the edge at which a level is sampled.
REQ-012 IDLE: if pb=1, go to PRESS1 and set cnt=0; else stay.
REQ-013 PRESS1, pb=1: if cnt==LONG_TICKS-1, pulse long_press and go to LONG_HELD; else increment cnt. Net effect: long_press is high in the cycle after edge e+LONG_TICKS, where e is the IDLE->PRESS1 edge.
REQ-014 PRESS1, pb=0: go to WAIT_SECOND and set cnt=0. On the same edge as cnt==LONG_TICKS-1, release wins and no long_press is issued.
REQ-015 LONG_HELD: if pb=0, go to IDLE; no pulse is ever emitted from this state.
REQ-016 WAIT_SECOND, pb=1: go to PRESS2. This takes priority even when cnt==DOUBLE_GAP-1 on the same edge.
REQ-017 WAIT_SECOND, pb=0: if cnt==DOUBLE_GAP-1, pulse short_press and go to IDLE; else increment cnt. Net effect: short_press is high after release edge r+DOUBLE_GAP.
REQ-018 PRESS2: if pb=0, pulse double_press and go to IDLE; any hold duration is accepted and there is no long detection in PRESS2.
REQ-019 All outputs SHALL be registered; each pulse is exactly one clk wide.
REQ-020 At most one of short_press, long_press and double_press SHALL be high in any cycle.
REQ-021 `cnt` SHALL never wrap; its maximum value is 254.
REQ-022 A held button SHALL never re-trigger: after LONG_HELD, a new classification requires release to IDLE and then a fresh press.

Reset
REQ-023 When rst_n=0, the block SHALL immediately and asynchronously enter IDLE, with cnt=0 and short_press, long_press, double_press and held all 0.
REQ-024 Reset asserted mid-sequence SHALL discard that sequence with no pulse. After deassertion, if pb=1, the next edge enters PRESS1 (the button counts as freshly pressed).
REQ-025 Reset deassertion is treated as synchronous to clk; no pulse SHALL occur in the first cycle after deassertion.

Structure
REQ-026 Package pb_event_pkg SHALL hold the state enum typedef and the constant CNT_W=8.
REQ-027 The block SHALL be a single module with no sub-module: one FSM plus one shared counter. It is placed directly downstream of the debounce block.
REQ-028 Parameters out of the legal range SHALL fail at elaboration.

Verification (LONG_TICKS=8, DOUBLE_GAP=4)
REQ-029 Short press: pb=1 for 3 edges, then 0 -> exactly one short_press pulse 4 cycles after the release edge; held=1 for 3 cycles; no other pulse.
REQ-030 Long press: pb=1 for 20 edges -> long_press pulse after entry edge +8; held=1 until release; no pulse on release.
REQ-031 Double press: pb=1 for 2 edges, 0 for 2 edges, 1 for 3 edges, 0 -> double_press pulse after the second release edge; no short_press.
REQ-032 Gap boundary: release gap of exactly 4 edges with the press on the 4th edge -> double_press (press wins); a gap of 5 -> short_press, then a new PRESS1.
REQ-033 Reset mid-operation: assert rst_n=0 for 2 cycles during PRESS1 at cnt=5 -> all outputs 0 immediately; with pb still 1 after release of reset, long_press arrives 8 edges after re-entry, not earlier.
